step_counter: RTL and testbench
===============================

# step_counter

Parametrised up/down step counter with synchronous load, modulo-MAX wrap or saturate mode, terminal-count and overflow flags, and a saturating overflow-event counter. It is the next generation of the fixed 8-bit free-running incrementer used as a tick/sequence source, and sits in the same place: a state-holding sequence generator that drives timers, address walkers and test pattern sources.

## Interface
Parameters:
- WIDTH, 8: counter width in bits.
- STEP, 1: increment/decrement amount; legal range 1..MAX.
- MAX, 255: terminal value; legal range 1..2^WIDTH-1. Count range is 0..MAX.
- INIT, 0: reset value of count; legal range 0..MAX.
- SAT, 0: 0 = wrap modulo MAX+1; 1 = saturate at 0/MAX.
- OVW, 8: width of ovf_cnt.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- en  in  1  advance count this cycle.
- dir  in  1  1 = up, 0 = down.
- ld  in  1  synchronous load; priority over en.
- ld_val  in  WIDTH  load value.
- count  out  WIDTH  current count.
- tc  out  1  terminal-count level.
- ovf  out  1  one-cycle overflow/underflow pulse.
- ovf_cnt  out  OVW  overflow events since reset/load, saturating.

## Operation
- Priority per edge: rst > ld > en > hold.
- ld=1: count <= min(ld_val, MAX); tc <= 0; ovf <= 0; ovf_cnt <= 0. en and dir are ignored.
- en=1, dir=1, ld=0: compute s = count + STEP at WIDTH+1 bits.
  - s <= MAX: count <= s.
  - s > MAX, SAT=0: count <= s - (MAX+1); ovf <= 1.
  - s > MAX, SAT=1: count <= MAX; ovf <= 1.
- en=1, dir=0, ld=0:
  - count >= STEP: count <= count - STEP.
  - count < STEP, SAT=0: count <= count + (MAX+1) - STEP; ovf <= 1.
  - count < STEP, SAT=1: count <= 0; ovf <= 1.
- tc on an advance: tc <= 1 iff the new count equals MAX with dir=1, or equals 0 with dir=0; otherwise tc <= 0.
- ovf_cnt: increments by 1 on every edge where ovf is set. It holds at 2^OVW-1 once reached.
- Hold (en=0, ld=0): count, tc and ovf_cnt keep their values; ovf <= 0.
- ovf is never high for two consecutive cycles unless consecutive advances overflow.
  - Saturate mode at MAX with en=1, dir=1 held: ovf stays high every cycle and ovf_cnt increments every cycle.
- A direction change mid-count needs no special handling; each cycle is evaluated independently.
- Out-of-range parameters (STEP=0, STEP>MAX, INIT>MAX) are illegal. Elaboration fails via a static assertion.

## Timing
- All outputs are registered. Inputs are sampled at the rising clk edge, and results are visible after that edge: 1-cycle latency from en/ld to count/tc/ovf.
- Reset values (asynchronous, immediate on rst rising, held while rst=1):
  - count = INIT
  - tc = 0
  - ovf = 0
  - ovf_cnt = 0
- After reset release:
  - The first edge with en=1 produces INIT±STEP.
  - No spurious ovf occurs on the release edge.
- Reset asserted mid-operation: all state is discarded at once. No partial update completes.
- ld and en in the same cycle: load wins, and no advance or ovf occurs that cycle.
- Combinational path from inputs to outputs: none.

## Test plan
- Defaults (WIDTH=8, STEP=1, MAX=255, SAT=0):
  - Stimulus: reset, then en=1, dir=1 for 256 cycles.
  - Required: count 1,2,…,255,0; tc=1 only in the cycle count=255; ovf=1 only in the cycle count returns to 0; ovf_cnt=1.
- MAX=9, STEP=3, SAT=0:
  - Stimulus: ld_val=8 load, then up 2 cycles, then down 3 cycles.
  - Required: count 8 → 1 (ovf) → 4 → 1 → 8 (ovf) → 5; ovf_cnt=2.
- MAX=9, STEP=3, SAT=1:
  - Stimulus: load 8, up 3 cycles.
  - Required: count 9 (ovf, tc=1), 9 (ovf), 9 (ovf); ovf_cnt=3.
  - Then: down 4 cycles.
  - Required: 6, 3, 0 (tc=1, no ovf), 0 (ovf).
- Priority/clamp (defaults, MAX=200):
  - Stimulus: ld=1, en=1, ld_val=250 in the same cycle.
  - Required: count=200, ovf=0, ovf_cnt=0.
  - Then: en=0 for 5 cycles.
  - Required: count holds at 200 and ovf stays 0.
- Reset mid-run (INIT=17):
  - Stimulus: count up to 40, then assert rst between clock edges.
  - Required: count=17, tc=ovf=0, ovf_cnt=0 before the next edge, held while rst=1.
  - Then: after release with en=1.
  - Required: 18.
- OVW=2, MAX=3, STEP=1, SAT=0:
  - Stimulus: up for 20 cycles.
  - Required: ovf pulses 5 times; ovf_cnt saturates at 3 and holds.

Source files
------------

// File: rtl/step_counter_if.sv
// Control and status bundle for step_counter: advance/load requests in,
// registered count and flags out.
interface step_counter_if #(
    parameter int WIDTH = 8,
    parameter int OVW   = 8
);
    logic             en;
    logic             dir;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;
    logic [OVW-1:0]   ovf_cnt;

    modport master (
        output en, dir, ld, ld_val,
        input  count, tc, ovf, ovf_cnt
    );

    modport slave (
        input  en, dir, ld, ld_val,
        output count, tc, ovf, ovf_cnt
    );
endinterface

// File: rtl/step_counter.sv
// Up/down step counter over 0..MAX with load, wrap-or-saturate behaviour,
// terminal-count level, overflow pulse and a saturating overflow-event counter.
module step_counter #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int MAX   = 255,
    parameter int INIT  = 0,
    parameter int SAT   = 0,
    parameter int OVW   = 8
) (
    input logic          clk,
    input logic          rst,
    step_counter_if.slave bus
);

    if (MAX < 1 || (MAX >> WIDTH) != 0) begin : g_bad_max
        $error("step_counter: MAX must be in 1..2**WIDTH-1");
    end
    if (STEP < 1 || STEP > MAX) begin : g_bad_step
        $error("step_counter: STEP must be in 1..MAX");
    end
    if (INIT < 0 || INIT > MAX) begin : g_bad_init
        $error("step_counter: INIT must be in 0..MAX");
    end

    // One extra bit so count+STEP and count+MAX+1 never overflow before the range test.
    localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   MOD_X  = (WIDTH+1)'(MAX + 1);
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [OVW-1:0]   ovf_cnt_q, ovf_cnt_d;

    logic [WIDTH:0]   count_x;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH:0]   wrap_up;
    logic [WIDTH:0]   wrap_down;

    always_comb begin
        count_x   = {1'b0, count_q};
        sum_up    = count_x + STEP_X;
        wrap_up   = sum_up - MOD_X;
        wrap_down = count_x + MOD_X - STEP_X;

        count_d   = count_q;
        tc_d      = tc_q;
        ovf_d     = 1'b0;
        ovf_cnt_d = ovf_cnt_q;

        if (bus.ld) begin
            count_d   = (bus.ld_val > MAX_W) ? MAX_W : bus.ld_val;
            tc_d      = 1'b0;
            ovf_cnt_d = '0;
        end else if (bus.en) begin
            if (bus.dir) begin
                if (sum_up <= MAX_X) begin
                    count_d = sum_up[WIDTH-1:0];
                end else begin
                    ovf_d   = 1'b1;
                    count_d = (SAT != 0) ? MAX_W : wrap_up[WIDTH-1:0];
                end
            end else begin
                if (count_x >= STEP_X) begin
                    count_d = count_q - STEP_W;
                end else begin
                    ovf_d   = 1'b1;
                    count_d = (SAT != 0) ? '0 : wrap_down[WIDTH-1:0];
                end
            end
            tc_d = bus.dir ? (count_d == MAX_W) : (count_d == '0);
            if (ovf_d && (ovf_cnt_q != '1)) begin
                ovf_cnt_d = ovf_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= INIT_W;
            tc_q      <= 1'b0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            count_q   <= count_d;
            tc_q      <= tc_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.tc      = tc_q;
    assign bus.ovf     = ovf_q;
    assign bus.ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_step_counter.sv
// Lockstep bench: six step_counter configurations share one stimulus stream and
// are compared every cycle against a queued reference model, plus literal sequences.
module tb_step_counter;

    localparam int N = 6;
    localparam int P_W    [N] = '{8, 4, 4, 8, 8, 2};
    localparam int P_STEP [N] = '{1, 3, 3, 1, 1, 1};
    localparam int P_MAX  [N] = '{255, 9, 9, 200, 255, 3};
    localparam int P_INIT [N] = '{0, 0, 0, 0, 17, 0};
    localparam int P_SAT  [N] = '{0, 0, 1, 0, 0, 0};
    localparam int P_OVW  [N] = '{8, 8, 8, 8, 8, 2};

    typedef struct packed {
        logic [7:0] count;
        logic       tc;
        logic       ovf;
        logic [7:0] ovf_cnt;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       dir;
    logic       ld;
    logic [7:0] ld_val;

    int   checks = 0;
    int   errors = 0;
    exp_t ms [N];
    exp_t sb [$];

    step_counter_if #(.WIDTH(8), .OVW(8)) bus0 ();
    step_counter_if #(.WIDTH(4), .OVW(8)) bus1 ();
    step_counter_if #(.WIDTH(4), .OVW(8)) bus2 ();
    step_counter_if #(.WIDTH(8), .OVW(8)) bus3 ();
    step_counter_if #(.WIDTH(8), .OVW(8)) bus4 ();
    step_counter_if #(.WIDTH(2), .OVW(2)) bus5 ();

    assign bus0.en = en;  assign bus0.dir = dir;  assign bus0.ld = ld;  assign bus0.ld_val = ld_val;
    assign bus1.en = en;  assign bus1.dir = dir;  assign bus1.ld = ld;  assign bus1.ld_val = ld_val[3:0];
    assign bus2.en = en;  assign bus2.dir = dir;  assign bus2.ld = ld;  assign bus2.ld_val = ld_val[3:0];
    assign bus3.en = en;  assign bus3.dir = dir;  assign bus3.ld = ld;  assign bus3.ld_val = ld_val;
    assign bus4.en = en;  assign bus4.dir = dir;  assign bus4.ld = ld;  assign bus4.ld_val = ld_val;
    assign bus5.en = en;  assign bus5.dir = dir;  assign bus5.ld = ld;  assign bus5.ld_val = ld_val[1:0];

    step_counter #(.WIDTH(8), .STEP(1), .MAX(255), .INIT(0),  .SAT(0), .OVW(8))
        u0 (.clk(clk), .rst(rst), .bus(bus0));
    step_counter #(.WIDTH(4), .STEP(3), .MAX(9),   .INIT(0),  .SAT(0), .OVW(8))
        u1 (.clk(clk), .rst(rst), .bus(bus1));
    step_counter #(.WIDTH(4), .STEP(3), .MAX(9),   .INIT(0),  .SAT(1), .OVW(8))
        u2 (.clk(clk), .rst(rst), .bus(bus2));
    step_counter #(.WIDTH(8), .STEP(1), .MAX(200), .INIT(0),  .SAT(0), .OVW(8))
        u3 (.clk(clk), .rst(rst), .bus(bus3));
    step_counter #(.WIDTH(8), .STEP(1), .MAX(255), .INIT(17), .SAT(0), .OVW(8))
        u4 (.clk(clk), .rst(rst), .bus(bus4));
    step_counter #(.WIDTH(2), .STEP(1), .MAX(3),   .INIT(0),  .SAT(0), .OVW(2))
        u5 (.clk(clk), .rst(rst), .bus(bus5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t reset_val(int k);
        exp_t r;
        r         = '0;
        r.count   = 8'(P_INIT[k]);
        return r;
    endfunction

    // Reference behaviour written straight from the operating rules, using plain integers.
    function automatic exp_t model(exp_t cur, int k, logic l, logic [7:0] lv, logic e, logic d);
        exp_t n;
        int   c;
        int   lvi;
        n     = cur;
        n.ovf = 1'b0;
        if (l) begin
            lvi       = int'(lv) & ((1 << P_W[k]) - 1);
            n.count   = 8'((lvi > P_MAX[k]) ? P_MAX[k] : lvi);
            n.tc      = 1'b0;
            n.ovf_cnt = '0;
        end else if (e) begin
            c = int'(cur.count);
            if (d) begin
                c = c + P_STEP[k];
                if (c > P_MAX[k]) begin
                    n.ovf = 1'b1;
                    c     = (P_SAT[k] != 0) ? P_MAX[k] : c - (P_MAX[k] + 1);
                end
            end else begin
                if (c >= P_STEP[k]) begin
                    c = c - P_STEP[k];
                end else begin
                    n.ovf = 1'b1;
                    c     = (P_SAT[k] != 0) ? 0 : c + P_MAX[k] + 1 - P_STEP[k];
                end
            end
            n.count = 8'(c);
            n.tc    = d ? (c == P_MAX[k]) : (c == 0);
            if (n.ovf && int'(cur.ovf_cnt) < (1 << P_OVW[k]) - 1)
                n.ovf_cnt = cur.ovf_cnt + 8'd1;
        end
        return n;
    endfunction

    function automatic exp_t get_obs(int k);
        exp_t o;
        o = '0;
        case (k)
            0: begin o.count = bus0.count; o.tc = bus0.tc; o.ovf = bus0.ovf; o.ovf_cnt = bus0.ovf_cnt; end
            1: begin o.count = {4'b0, bus1.count}; o.tc = bus1.tc; o.ovf = bus1.ovf; o.ovf_cnt = bus1.ovf_cnt; end
            2: begin o.count = {4'b0, bus2.count}; o.tc = bus2.tc; o.ovf = bus2.ovf; o.ovf_cnt = bus2.ovf_cnt; end
            3: begin o.count = bus3.count; o.tc = bus3.tc; o.ovf = bus3.ovf; o.ovf_cnt = bus3.ovf_cnt; end
            4: begin o.count = bus4.count; o.tc = bus4.tc; o.ovf = bus4.ovf; o.ovf_cnt = bus4.ovf_cnt; end
            default: begin
                o.count = {6'b0, bus5.count}; o.tc = bus5.tc; o.ovf = bus5.ovf; o.ovf_cnt = {6'b0, bus5.ovf_cnt};
            end
        endcase
        return o;
    endfunction

    function automatic string fmt(exp_t x);
        return $sformatf("count=%0d tc=%0d ovf=%0d ovf_cnt=%0d", x.count, x.tc, x.ovf, x.ovf_cnt);
    endfunction

    // Applies one cycle of stimulus, queues every model's expectation, and returns #1 after the edge.
    task automatic drive(input logic e, input logic d, input logic l, input logic [7:0] lv);
        en     = e;
        dir    = d;
        ld     = l;
        ld_val = lv;
        for (int k = 0; k < N; k++) begin
            ms[k] = model(ms[k], k, l, lv, e, d);
            sb.push_back(ms[k]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < N; k++) ms[k] = reset_val(k);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e, o;
        rst = 1'b1; en = 1'b0; dir = 1'b1; ld = 1'b0; ld_val = '0;
        #1;
        for (int k = 0; k < N; k++) begin
            ms[k] = reset_val(k);
            sb.push_back(ms[k]);
        end
        for (int k = 0; k < N; k++) begin
            e = sb.pop_front(); o = get_obs(k); checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL reset_async dut%0d: got %s want %s", k, fmt(o), fmt(e));
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 8'd0);
        for (int k = 0; k < N; k++) begin
            e = sb.pop_front(); o = get_obs(k); checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL reset_first_step dut%0d: got %s want %s", k, fmt(o), fmt(e));
            end
        end
        checks++;
        if (bus0.count !== 8'd1 || bus0.ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL first_step_u0: got count=%0d ovf=%0d want count=1 ovf=0", bus0.count, bus0.ovf);
        end
        checks++;
        if (bus4.count !== 8'd18) begin
            errors++;
            $display("[TB] FAIL first_step_u4: got %0d want 18", bus4.count);
        end
    endtask

    task automatic test_count_up();
        exp_t e, o;
        int   exp_c;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'd0);
            for (int k = 0; k < N; k++) begin
                e = sb.pop_front(); o = get_obs(k); checks++;
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL sb_count_up cyc%0d dut%0d: got %s want %s", i, k, fmt(o), fmt(e));
                end
            end
            exp_c = (i + 1) % 256;
            checks++;
            if (bus0.count !== 8'(exp_c) || bus0.tc !== (exp_c == 255) || bus0.ovf !== (i == 255)) begin
                errors++;
                $display("[TB] FAIL count_up_u0 cyc%0d: got count=%0d tc=%0d ovf=%0d want count=%0d tc=%0d ovf=%0d",
                         i, bus0.count, bus0.tc, bus0.ovf, exp_c, exp_c == 255, i == 255);
            end
        end
        checks++;
        if (bus0.ovf_cnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL count_up_ovf_cnt: got %0d want 1", bus0.ovf_cnt);
        end
    endtask

    task automatic test_wrap_step();
        exp_t e, o;
        logic dirs  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int   exp_c [5] = '{1, 4, 1, 8, 5};
        logic exp_o [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) drive(1'b0, 1'b0, 1'b1, 8'd8);
            else        drive(1'b1, dirs[i-1], 1'b0, 8'd0);
            for (int k = 0; k < N; k++) begin
                e = sb.pop_front(); o = get_obs(k); checks++;
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL sb_wrap_step step%0d dut%0d: got %s want %s", i, k, fmt(o), fmt(e));
                end
            end
            checks++;
            if (i == 0 && bus1.count !== 4'd8) begin
                errors++;
                $display("[TB] FAIL wrap_load_u1: got %0d want 8", bus1.count);
            end else if (i > 0 && (bus1.count !== 4'(exp_c[i-1]) || bus1.ovf !== exp_o[i-1])) begin
                errors++;
                $display("[TB] FAIL wrap_seq_u1 step%0d: got count=%0d ovf=%0d want count=%0d ovf=%0d",
                         i, bus1.count, bus1.ovf, exp_c[i-1], exp_o[i-1]);
            end
        end
        checks++;
        if (bus1.ovf_cnt !== 8'd2) begin
            errors++;
            $display("[TB] FAIL wrap_ovf_cnt_u1: got %0d want 2", bus1.ovf_cnt);
        end
    endtask

    task automatic test_saturate();
        exp_t e, o;
        logic dirs  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int   exp_c [7] = '{9, 9, 9, 6, 3, 0, 0};
        logic exp_o [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic exp_t_ [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 8'd8);
        for (int k = 0; k < N; k++) begin
            e = sb.pop_front(); o = get_obs(k); checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL sb_sat_load dut%0d: got %s want %s", k, fmt(o), fmt(e));
            end
        end
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, dirs[i], 1'b0, 8'd0);
            for (int k = 0; k < N; k++) begin
                e = sb.pop_front(); o = get_obs(k); checks++;
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL sb_saturate step%0d dut%0d: got %s want %s", i, k, fmt(o), fmt(e));
                end
            end
            checks++;
            if (bus2.count !== 4'(exp_c[i]) || bus2.ovf !== exp_o[i] || bus2.tc !== exp_t_[i]) begin
                errors++;
                $display("[TB] FAIL sat_seq_u2 step%0d: got count=%0d ovf=%0d tc=%0d want count=%0d ovf=%0d tc=%0d",
                         i, bus2.count, bus2.ovf, bus2.tc, exp_c[i], exp_o[i], exp_t_[i]);
            end
            if (i == 2) begin
                checks++;
                if (bus2.ovf_cnt !== 8'd3) begin
                    errors++;
                    $display("[TB] FAIL sat_ovf_cnt_u2: got %0d want 3", bus2.ovf_cnt);
                end
            end
        end
    endtask

    task automatic test_load_priority();
        exp_t e, o;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 3)       drive(1'b1, 1'b1, 1'b0, 8'd0);
            else if (i == 3) drive(1'b1, 1'b1, 1'b1, 8'd250);
            else             drive(1'b0, 1'b1, 1'b0, 8'd0);
            for (int k = 0; k < N; k++) begin
                e = sb.pop_front(); o = get_obs(k); checks++;
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL sb_load_priority step%0d dut%0d: got %s want %s", i, k, fmt(o), fmt(e));
                end
            end
            if (i >= 3) begin
                checks++;
                if (bus3.count !== 8'd200 || bus3.ovf !== 1'b0 || bus3.ovf_cnt !== 8'd0) begin
                    errors++;
                    $display("[TB] FAIL load_clamp_u3 step%0d: got count=%0d ovf=%0d ovf_cnt=%0d want 200/0/0",
                             i, bus3.count, bus3.ovf, bus3.ovf_cnt);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, o;
        do_reset();
        for (int i = 0; i < 23; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'd0);
            for (int k = 0; k < N; k++) begin
                e = sb.pop_front(); o = get_obs(k); checks++;
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL sb_reset_mid cyc%0d dut%0d: got %s want %s", i, k, fmt(o), fmt(e));
                end
            end
        end
        checks++;
        if (bus4.count !== 8'd40) begin
            errors++;
            $display("[TB] FAIL pre_reset_u4: got %0d want 40", bus4.count);
        end
        // Assert reset between edges, then look again after an edge with rst still high.
        #2;
        rst = 1'b1;
        for (int k = 0; k < N; k++) ms[k] = reset_val(k);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) #1;
            else begin @(posedge clk); #1; end
            for (int k = 0; k < N; k++) sb.push_back(ms[k]);
            for (int k = 0; k < N; k++) begin
                e = sb.pop_front(); o = get_obs(k); checks++;
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL reset_mid pass%0d dut%0d: got %s want %s", pass, k, fmt(o), fmt(e));
                end
            end
        end
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 8'd0);
        for (int k = 0; k < N; k++) begin
            e = sb.pop_front(); o = get_obs(k); checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL sb_after_reset dut%0d: got %s want %s", k, fmt(o), fmt(e));
            end
        end
        checks++;
        if (bus4.count !== 8'd18) begin
            errors++;
            $display("[TB] FAIL after_reset_u4: got %0d want 18", bus4.count);
        end
    endtask

    task automatic test_ovf_sat();
        exp_t e, o;
        int   pulses = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'd0);
            for (int k = 0; k < N; k++) begin
                e = sb.pop_front(); o = get_obs(k); checks++;
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL sb_ovf_sat cyc%0d dut%0d: got %s want %s", i, k, fmt(o), fmt(e));
                end
            end
            if (bus5.ovf === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 5 || bus5.ovf_cnt !== 2'd3) begin
            errors++;
            $display("[TB] FAIL ovf_sat_u5: got pulses=%0d ovf_cnt=%0d want pulses=5 ovf_cnt=3", pulses, bus5.ovf_cnt);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, o;
        logic l, en_r, d;
        logic [7:0] lv;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            l    = ($urandom_range(0, 15) == 0);
            en_r = ($urandom_range(0, 3) != 0);
            d    = 1'($urandom_range(0, 1));
            lv   = 8'($urandom_range(0, 255));
            drive(en_r, d, l, lv);
            for (int k = 0; k < N; k++) begin
                e = sb.pop_front(); o = get_obs(k); checks++;
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL sb_back_to_back cyc%0d dut%0d: got %s want %s", i, k, fmt(o), fmt(e));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_step();
        test_saturate();
        test_load_priority();
        test_reset_mid();
        test_ovf_sat();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
